// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture controller: screen geometry defaults,
// FSM state encoding and the RGB565 -> RGB332 bit mapping.
package cam_pkg;

   localparam int CAM_SCREEN_X_DEF = 320;
   localparam int CAM_SCREEN_Y_DEF = 240;
   localparam int CAM_AW_DEF       = 17;
   localparam int CAM_DW_DEF       = 8;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_SOF = 3'd1,
      ST_BYTE_HI  = 3'd2,
      ST_BYTE_LO  = 3'd3,
      ST_EOF      = 3'd4
   } cap_state_t;

   // Keep the top 3 bits of red and green and the top 2 bits of blue.
   function automatic logic [7:0] rgb565_to_rgb332(input logic [7:0] hi_byte,
                                                   input logic [7:0] lo_byte);
      return {hi_byte[7:5], hi_byte[2:0], lo_byte[4:3]};
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous input with rising/falling edge
// detection against the previous synchronized sample.
module sync_edge #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] i_async,
   output logic [W-1:0] o_sync,
   output logic [W-1:0] o_rise,
   output logic [W-1:0] o_fall
);

   logic [W-1:0] r_meta;
   logic [W-1:0] r_sync;
   logic [W-1:0] r_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= '0;
         r_sync <= '0;
         r_prev <= '0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_sync = r_sync;
   assign o_rise = r_sync & ~r_prev;
   assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/cam_capture_ctrl.sv
// Captures RGB565 pixels from a camera byte bus, converts them to RGB332 and
// writes them into a CAM_SCREEN_X by CAM_SCREEN_Y frame buffer.
module cam_capture_ctrl
   import cam_pkg::*;
#(
   parameter int CAM_SCREEN_X = CAM_SCREEN_X_DEF,
   parameter int CAM_SCREEN_Y = CAM_SCREEN_Y_DEF,
   parameter int AW           = CAM_AW_DEF,
   parameter int DW           = CAM_DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          capture_en,
   input  logic          CAM_pclk,
   input  logic          CAM_href,
   input  logic          CAM_vsync,
   input  logic [7:0]    CAM_px_data,
   output logic [AW-1:0] DP_RAM_addr_in,
   output logic [DW-1:0] DP_RAM_data_in,
   output logic          DP_RAM_regW,
   output logic          frame_done,
   output logic          busy,
   output logic          overflow
);

   localparam int CW = $clog2(CAM_SCREEN_X + 1);
   localparam int RW = $clog2(CAM_SCREEN_Y + 1);
   localparam logic [CW-1:0] L_X_MAX  = CW'(CAM_SCREEN_X);
   localparam logic [RW-1:0] L_Y_MAX  = RW'(CAM_SCREEN_Y);
   localparam logic [AW-1:0] L_X_STEP = AW'(CAM_SCREEN_X);

   logic       w_pclk_s, w_pclk_rise, w_pclk_fall;
   logic       w_href_s, w_href_rise, w_href_fall;
   logic       w_vsync_s, w_vsync_rise, w_vsync_fall;
   logic [7:0] w_data_s, w_data_rise, w_data_fall;
   logic       w_unused;

   sync_edge #(.W(1)) u_sync_pclk (
      .clk(clk), .rst(rst), .i_async(CAM_pclk),
      .o_sync(w_pclk_s), .o_rise(w_pclk_rise), .o_fall(w_pclk_fall)
   );

   sync_edge #(.W(1)) u_sync_href (
      .clk(clk), .rst(rst), .i_async(CAM_href),
      .o_sync(w_href_s), .o_rise(w_href_rise), .o_fall(w_href_fall)
   );

   sync_edge #(.W(1)) u_sync_vsync (
      .clk(clk), .rst(rst), .i_async(CAM_vsync),
      .o_sync(w_vsync_s), .o_rise(w_vsync_rise), .o_fall(w_vsync_fall)
   );

   // Data goes through the same latency as pclk so the byte is aligned with pe.
   sync_edge #(.W(8)) u_sync_data (
      .clk(clk), .rst(rst), .i_async(CAM_px_data),
      .o_sync(w_data_s), .o_rise(w_data_rise), .o_fall(w_data_fall)
   );

   assign w_unused = ^{w_pclk_s, w_pclk_fall, w_href_rise, w_vsync_s,
                       w_data_rise, w_data_fall};

   cap_state_t r_state;
   cap_state_t w_state_nxt;

   logic            w_pe;
   logic            w_sof;
   logic            w_line_end;
   logic            w_take_hi;
   logic            w_take_lo;
   logic            w_in_window;

   logic [RW-1:0]   r_row;
   logic [CW-1:0]   r_col;
   logic [AW-1:0]   r_row_base;
   logic [AW-1:0]   r_addr;
   logic [DW-1:0]   r_data;
   logic [7:0]      r_hi_byte;
   logic            r_we;
   logic            r_overflow;

   assign w_pe        = w_pclk_rise;
   assign w_in_window = (r_col < L_X_MAX) && (r_row < L_Y_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Edge priority inside a line: vsync rise, then href fall, then a byte on pe.
   always_comb begin
      w_state_nxt = r_state;
      w_sof       = 1'b0;
      w_line_end  = 1'b0;
      w_take_hi   = 1'b0;
      w_take_lo   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (capture_en) begin
               w_state_nxt = ST_WAIT_SOF;
            end
         end
         ST_WAIT_SOF: begin
            if (w_vsync_fall) begin
               w_sof       = 1'b1;
               w_state_nxt = ST_BYTE_HI;
            end
         end
         ST_BYTE_HI, ST_BYTE_LO: begin
            if (w_vsync_rise) begin
               w_state_nxt = ST_EOF;
            end else if (w_href_fall) begin
               w_line_end  = 1'b1;
               w_state_nxt = ST_BYTE_HI;
            end else if (w_pe && w_href_s) begin
               if (r_state == ST_BYTE_HI) begin
                  w_take_hi   = 1'b1;
                  w_state_nxt = ST_BYTE_LO;
               end else begin
                  w_take_lo   = 1'b1;
                  w_state_nxt = ST_BYTE_HI;
               end
            end
         end
         ST_EOF: begin
            w_state_nxt = capture_en ? ST_WAIT_SOF : ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Row base advances by one line per href fall, so the address needs only an adder.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_row      <= '0;
         r_col      <= '0;
         r_row_base <= '0;
         r_addr     <= '0;
         r_data     <= '0;
         r_hi_byte  <= '0;
         r_we       <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_we <= 1'b0;
         if (w_sof) begin
            r_row      <= '0;
            r_col      <= '0;
            r_row_base <= '0;
            r_addr     <= '0;
            r_hi_byte  <= '0;
            r_overflow <= 1'b0;
         end
         if (w_line_end) begin
            r_col     <= '0;
            r_hi_byte <= '0;
            if (r_row < L_Y_MAX) begin
               r_row      <= r_row + RW'(1);
               r_row_base <= r_row_base + L_X_STEP;
            end
         end
         if (w_take_hi) begin
            r_hi_byte <= w_data_s;
         end
         if (w_take_lo) begin
            if (w_in_window) begin
               r_we   <= 1'b1;
               r_addr <= r_row_base + AW'(r_col);
               r_data <= DW'(rgb565_to_rgb332(r_hi_byte, w_data_s));
            end else begin
               r_overflow <= 1'b1;
            end
            if (r_col < L_X_MAX) begin
               r_col <= r_col + CW'(1);
            end
         end
      end
   end

   assign DP_RAM_addr_in = r_addr;
   assign DP_RAM_data_in = r_data;
   assign DP_RAM_regW    = r_we;
   assign overflow       = r_overflow;
   assign frame_done     = (r_state == ST_EOF);
   assign busy           = (r_state != ST_IDLE);

endmodule
